// File: rtl/urc_telem_tx.sv
// UART telemetry transmitter: valid/ready byte FIFO drained as 8N1 serial frames on txd.
// Define URC_TELEM_TX_PARITY_EN to insert an even-parity bit before stop (8E1 frames).
module urc_telem_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        OSCCLK,
    input  logic                        SYSRST,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   FULL_CNT  = (PW+1)'(FIFO_DEPTH);

`ifdef URC_TELEM_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          empty;
    logic          baud_end;
`ifdef URC_TELEM_TX_PARITY_EN
    logic          par_bit;
`endif

    assign empty    = (fifo_count == '0);
    assign tx_ready = (fifo_count != FULL_CNT);
    assign push     = tx_valid && tx_ready;
    assign baud_end = (baud_cnt == BAUD_LAST);
    // The head is taken either from idle or straight out of a finishing stop bit,
    // so back-to-back frames never see an idle cycle.
    assign pop      = !empty && ((state == IDLE) || ((state == STOP) && baud_end));
    assign busy     = (state != IDLE) || !empty;

    always_ff @(posedge OSCCLK) begin
        if (SYSRST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge OSCCLK) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    // Shift register presents the next data bit at shreg[0] at every bit boundary.
    always_ff @(posedge OSCCLK) begin
        if (pop) begin
            shreg <= mem[rd_ptr];
`ifdef URC_TELEM_TX_PARITY_EN
            par_bit <= ^mem[rd_ptr];
`endif
        end else if (((state == START) || (state == DATA)) && baud_end) begin
            shreg <= shreg >> 1;
        end
    end

    always_ff @(posedge OSCCLK) begin
        if (SYSRST) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            txd      <= 1'b1;
        end else begin
            // Every non-idle transition happens on baud_end, so the counter is 0 on entry.
            if (state == IDLE || baud_end) baud_cnt <= '0;
            else                           baud_cnt <= baud_cnt + 1'b1;
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        state <= START;
                        txd   <= 1'b0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        state <= DATA;
                        txd   <= shreg[0];
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
`ifdef URC_TELEM_TX_PARITY_EN
                            state   <= PARITY;
                            txd     <= par_bit;
`else
                            state   <= STOP;
                            txd     <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            txd     <= shreg[0];
                        end
                    end
                end
`ifdef URC_TELEM_TX_PARITY_EN
                PARITY: begin
                    if (baud_end) begin
                        state <= STOP;
                        txd   <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_end) begin
                        if (pop) begin
                            state <= START;
                            txd   <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_urc_telem_tx.sv
// Self-checking bench for urc_telem_tx: directed stimulus, byte scoreboard, serial frame decoder.
`timescale 1ns/1ps
module tb_urc_telem_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef URC_TELEM_TX_PARITY_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif
    localparam int FRAME   = BITS * CPB;
    localparam int STOP_PH = BITS;

    logic          OSCCLK   = 1'b0;
    logic          SYSRST   = 1'b1;
    logic [7:0]    tx_data  = 8'h00;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          txd;
    logic          busy;
    logic [CW-1:0] fifo_count;

    int         n_vec  = 0;
    int         n_err  = 0;
    int         cyc    = 0;
    int         frames = 0;
    logic [7:0] exp_q [$];

    urc_telem_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .OSCCLK(OSCCLK), .SYSRST(SYSRST), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .txd(txd), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 OSCCLK = ~OSCCLK;
    always @(posedge OSCCLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with tx_valid still high.
    task automatic push_byte(input logic [7:0] b, input int budget, output int acc_cyc);
        logic r;
        logic ok;
        ok = 1'b0;
        acc_cyc = -1;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < budget; i++) begin
            r = tx_ready;
            @(posedge OSCCLK);
            if (r === 1'b1) begin
                exp_q.push_back(b);
                ok = 1'b1;
                @(negedge OSCCLK);
                acc_cyc = cyc;
                break;
            end
            @(negedge OSCCLK);
        end
        check("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input int budget, output int waited);
        waited = 0;
        while (busy !== 1'b0 && waited < budget) begin
            @(negedge OSCCLK);
            waited++;
        end
    endtask

    // Serial decoder: samples every negedge, checks each bit is stable for CPB cycles.
    initial begin : monitor
        int phase;
        int cnt;
        logic win;
        logic stable;
        logic [7:0] byte_r;
        logic [7:0] expb;
        phase = 0; cnt = 0; win = 1'b1; stable = 1'b1; byte_r = 8'h00;
        forever begin
            @(negedge OSCCLK);
            if (SYSRST === 1'b1) begin
                phase = 0;
            end else if (phase == 0) begin
                if (txd === 1'b0) begin
                    phase = 1; cnt = 1; win = 1'b0; stable = 1'b1;
                end
            end else begin
                if (cnt == 0) begin
                    win = txd; stable = 1'b1;
                end else if (txd !== win) begin
                    stable = 1'b0;
                end
                cnt++;
                if (cnt == CPB) begin
                    cnt = 0;
                    check("bit_width", 32'(stable), 32'd1);
                    if (phase == STOP_PH) begin
                        check("stop_bit", 32'(win), 32'd1);
                        check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) begin
                            expb = exp_q.pop_front();
                            check("rx_byte", 32'(byte_r), 32'(expb));
                        end
                        frames++;
                        phase = 0;
                    end else begin
                        if (phase >= 2 && phase <= 9) byte_r[3'(phase - 2)] = win;
`ifdef URC_TELEM_TX_PARITY_EN
                        if (phase == 10) check("parity_bit", 32'(win), 32'(^byte_r));
`endif
                        phase++;
                    end
                end
            end
        end
    end

    initial begin : stim
        int k;
        int t0;
        int f0;
        int acc;
        logic all_high;
        logic [7:0] burst [6];
        burst = '{8'h00, 8'hFF, 8'h55, 8'h3C, 8'h81, 8'h7E};

        // reset values
        repeat (3) @(posedge OSCCLK);
        @(negedge OSCCLK);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        SYSRST = 1'b0;
        @(negedge OSCCLK);
        check("rel_txd", 32'(txd), 32'd1);
        check("rel_ready", 32'(tx_ready), 32'd1);
        check("rel_busy", 32'(busy), 32'd0);
        check("rel_count", 32'(fifo_count), 32'd0);
        all_high = 1'b1;
        repeat (50) begin
            @(negedge OSCCLK);
            if (txd !== 1'b1) all_high = 1'b0;
        end
        check("idle_high", 32'(all_high), 32'd1);

        // single byte
        f0 = frames;
        tx_data = 8'hA5; tx_valid = 1'b1; exp_q.push_back(8'hA5);
        @(posedge OSCCLK);
        @(negedge OSCCLK);
        tx_valid = 1'b0;
        check("push_count", 32'(fifo_count), 32'd1);
        check("push_busy", 32'(busy), 32'd1);
        check("pre_start_txd", 32'(txd), 32'd1);
        @(negedge OSCCLK);
        check("start_txd", 32'(txd), 32'd0);
        check("pop_count", 32'(fifo_count), 32'd0);
        wait_idle(200, k);
        check("single_len", 32'(k), 32'(FRAME));
        check("single_frames", 32'(frames), 32'(f0 + 1));
        check("single_q", 32'(exp_q.size()), 32'd0);

        // burst with backpressure
        repeat (5) @(negedge OSCCLK);
        f0 = frames;
        push_byte(burst[0], 200, t0);
        for (int i = 1; i < 5; i++) push_byte(burst[i], 200, acc);
        check("burst_full_count", 32'(fifo_count), 32'd4);
        check("burst_ready_low", 32'(tx_ready), 32'd0);
        push_byte(burst[5], 400, acc);
        tx_valid = 1'b0;
        check("burst_last_accept", 32'(acc - t0), 32'(FRAME + 2));
        wait_idle(2000, k);
        check("burst_total", 32'(cyc - t0), 32'(6 * FRAME + 1));
        check("burst_frames", 32'(frames), 32'(f0 + 6));
        check("burst_q", 32'(exp_q.size()), 32'd0);

        // simultaneous push and pop at end of stop
        repeat (5) @(negedge OSCCLK);
        f0 = frames;
        push_byte(8'h11, 200, t0);
        push_byte(8'h22, 200, acc);
        push_byte(8'h33, 200, acc);
        tx_valid = 1'b0;
        while (cyc < t0 + FRAME) @(negedge OSCCLK);
        check("swap_pre_count", 32'(fifo_count), 32'd2);
        check("swap_pre_txd", 32'(txd), 32'd1);
        check("swap_pre_ready", 32'(tx_ready), 32'd1);
        tx_data = 8'h44; tx_valid = 1'b1; exp_q.push_back(8'h44);
        @(posedge OSCCLK);
        @(negedge OSCCLK);
        tx_valid = 1'b0;
        check("swap_count", 32'(fifo_count), 32'd2);
        check("swap_restart", 32'(txd), 32'd0);
        wait_idle(2000, k);
        check("swap_frames", 32'(frames), 32'(f0 + 4));
        check("swap_q", 32'(exp_q.size()), 32'd0);

        // reset during data bit 3 of 0x0F
        repeat (5) @(negedge OSCCLK);
        push_byte(8'h0F, 200, t0);
        push_byte(8'hA1, 200, acc);
        push_byte(8'hB2, 200, acc);
        tx_valid = 1'b0;
        while (cyc < t0 + 18) @(negedge OSCCLK);
        check("mid_count", 32'(fifo_count), 32'd2);
        check("mid_busy", 32'(busy), 32'd1);
        SYSRST = 1'b1;
        exp_q.delete();
        @(negedge OSCCLK);
        check("mid_rst_txd", 32'(txd), 32'd1);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(tx_ready), 32'd1);
        SYSRST = 1'b0;
        f0 = frames;
        all_high = 1'b1;
        repeat (100) begin
            @(negedge OSCCLK);
            if (txd !== 1'b1) all_high = 1'b0;
        end
        check("mid_no_tx", 32'(all_high), 32'd1);
        check("mid_no_frames", 32'(frames), 32'(f0));

        // pointer wrap: 20 bytes through a 4-deep FIFO
        f0 = frames;
        for (int i = 0; i < 20; i++) push_byte(8'(i), 400, acc);
        tx_valid = 1'b0;
        wait_idle(3000, k);
        check("wrap_busy", 32'(busy), 32'd0);
        check("wrap_frames", 32'(frames), 32'(f0 + 20));
        check("wrap_q", 32'(exp_q.size()), 32'd0);
        check("wrap_count", 32'(fifo_count), 32'd0);

        repeat (5) @(negedge OSCCLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
